// File: rtl/game_pkg.sv
// Shared types, field widths and the key-to-step helper for the chase game.
package game_pkg;

  localparam int unsigned X_W    = 6;
  localparam int unsigned Y_W    = 5;
  localparam int unsigned TYPE_W = 2;
  localparam int unsigned OBJ_W  = TYPE_W + X_W + Y_W;

  // Object type codes as stored in the top bits of an object RAM entry
  localparam logic [TYPE_W-1:0] TYPE_HIDDEN = 2'd0;
  localparam logic [TYPE_W-1:0] TYPE_MAN    = 2'd1;
  localparam logic [TYPE_W-1:0] TYPE_CHASER = 2'd2;
  localparam logic [TYPE_W-1:0] TYPE_CAUGHT = 2'd3;

  localparam logic [2:0] SLOT_MAN = 3'd0;
  localparam logic [2:0] SLOT_CHS = 3'd1;

  // Bit positions inside one actor's key nibble
  localparam int unsigned KEY_UP = 0;
  localparam int unsigned KEY_DN = 1;
  localparam int unsigned KEY_LT = 2;
  localparam int unsigned KEY_RT = 3;

  typedef enum logic [1:0] {
    StIdle,
    StUpdate,
    StWrite
  } state_e;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } pos_t;

  // One tile step from a key nibble: up > down > left > right, clamped at the grid edges
  function automatic pos_t step_pos(input logic [3:0]     keys,
                                    input pos_t           pos,
                                    input logic [X_W-1:0] x_max,
                                    input logic [Y_W-1:0] y_max);
    pos_t res;
    res = pos;
    if (keys[KEY_UP]) begin
      if (pos.y != '0) res.y = pos.y - Y_W'(1);
    end else if (keys[KEY_DN]) begin
      if (pos.y < y_max) res.y = pos.y + Y_W'(1);
    end else if (keys[KEY_LT]) begin
      if (pos.x != '0) res.x = pos.x - X_W'(1);
    end else if (keys[KEY_RT]) begin
      if (pos.x < x_max) res.x = pos.x + X_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchroniser for an asynchronous level, followed by a one-cycle rising-edge pulse.
module sync_rise_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic pulse_o
);

  logic meta_q, sync_q, prev_q;

  // Synchroniser chain plus the delayed copy used for edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/game_controller.sv
// Per-frame chase game logic: moves man and chaser, detects a catch, and sweeps
// the 8-entry object RAM once per frame. Also steps the background select.
module game_controller
  import game_pkg::*;
#(
  parameter int unsigned MOVE_DIV = 8,
  parameter int unsigned X_MAX    = 39,
  parameter int unsigned Y_MAX    = 29,
  parameter int unsigned MAN_X0   = 2,
  parameter int unsigned MAN_Y0   = 2,
  parameter int unsigned CHS_X0   = 37,
  parameter int unsigned CHS_Y0   = 27
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             iVS,
  input  logic [7:0]       iKEY,
  input  logic             change,
  output logic [1:0]       oBkg_sel,
  output logic [2:0]       oObjRam_addr,
  output logic [OBJ_W-1:0] oObjRam_data,
  output logic             oObjRam_we
);

  localparam int unsigned    CntW     = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MOVE_DIV - 1);
  localparam logic [X_W-1:0] XMax     = X_W'(X_MAX);
  localparam logic [Y_W-1:0] YMax     = Y_W'(Y_MAX);
  localparam pos_t           ManStart = '{x: X_W'(MAN_X0), y: Y_W'(MAN_Y0)};
  localparam pos_t           ChsStart = '{x: X_W'(CHS_X0), y: Y_W'(CHS_Y0)};

  logic vs_tick, chg_tick;
  logic [7:0] key_meta_q, key_sync_q;

  state_e           state_q, state_d;
  logic [2:0]       slot_q, slot_d;
  pos_t             man_q, man_d, chs_q, chs_d;
  logic             caught_q, caught_d;
  logic             restart_pend_q, restart_pend_d;
  logic [CntW-1:0]  frame_cnt_q, frame_cnt_d;
  logic [1:0]       bkg_q, bkg_d;
  logic [2:0]       addr_q, addr_d;
  logic [OBJ_W-1:0] data_q, data_d;
  logic             we_q, we_d;
  logic [OBJ_W-1:0] slot_data;

  sync_rise_detect u_vs_sync (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    (iVS),
    .pulse_o(vs_tick)
  );

  sync_rise_detect u_chg_sync (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    (change),
    .pulse_o(chg_tick)
  );

  // Key levels only need plain two-flop synchronisation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_meta_q <= '0;
      key_sync_q <= '0;
    end else begin
      key_meta_q <= iKEY;
      key_sync_q <= key_meta_q;
    end
  end

  // Entry presented for the slot currently being swept
  always_comb begin
    slot_data = '0;
    if (slot_q == SLOT_MAN) begin
      slot_data = {(caught_q ? TYPE_CAUGHT : TYPE_MAN), man_q};
    end else if (slot_q == SLOT_CHS) begin
      slot_data = {TYPE_CHASER, chs_q};
    end
  end

  // Next-state logic: frame update, RAM sweep and background/restart handling
  always_comb begin
    state_d        = state_q;
    slot_d         = slot_q;
    man_d          = man_q;
    chs_d          = chs_q;
    caught_d       = caught_q;
    restart_pend_d = restart_pend_q;
    frame_cnt_d    = frame_cnt_q;
    addr_d         = addr_q;
    data_d         = data_q;
    we_d           = 1'b0;
    bkg_d          = chg_tick ? bkg_q + 2'd1 : bkg_q;

    unique case (state_q)
      StIdle: begin
        if (vs_tick) state_d = StUpdate;
      end
      StUpdate: begin
        if (restart_pend_q) begin
          man_d          = ManStart;
          chs_d          = ChsStart;
          caught_d       = 1'b0;
          restart_pend_d = 1'b0;
          frame_cnt_d    = '0;
        end else if (!caught_q) begin
          if (frame_cnt_q == CntLast) begin
            frame_cnt_d = '0;
            man_d       = step_pos(key_sync_q[3:0], man_q, XMax, YMax);
            chs_d       = step_pos(key_sync_q[7:4], chs_q, XMax, YMax);
          end else begin
            frame_cnt_d = frame_cnt_q + CntW'(1);
          end
        end
        if (man_d == chs_d) caught_d = 1'b1;
        slot_d  = '0;
        state_d = StWrite;
      end
      StWrite: begin
        we_d   = 1'b1;
        addr_d = slot_q;
        data_d = slot_data;
        slot_d = slot_q + 3'd1;
        if (slot_q == 3'd7) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A change press while caught arms a restart for the next update
    if (chg_tick && caught_q) restart_pend_d = 1'b1;
  end

  // State and registered outputs; reset lands in StWrite so the RAM is initialised
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StWrite;
      slot_q         <= '0;
      man_q          <= ManStart;
      chs_q          <= ChsStart;
      caught_q       <= 1'b0;
      restart_pend_q <= 1'b0;
      frame_cnt_q    <= '0;
      bkg_q          <= '0;
      addr_q         <= '0;
      data_q         <= '0;
      we_q           <= 1'b0;
    end else begin
      state_q        <= state_d;
      slot_q         <= slot_d;
      man_q          <= man_d;
      chs_q          <= chs_d;
      caught_q       <= caught_d;
      restart_pend_q <= restart_pend_d;
      frame_cnt_q    <= frame_cnt_d;
      bkg_q          <= bkg_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
      we_q           <= we_d;
    end
  end

  assign oBkg_sel     = bkg_q;
  assign oObjRam_addr = addr_q;
  assign oObjRam_data = data_q;
  assign oObjRam_we   = we_q;

endmodule

// File: tb/tb_game_controller.sv
// Directed bench: one instance stepping every frame, one stepping every 8th frame.
module tb_game_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        iVS = 1'b0;
  logic        change = 1'b0;
  logic [7:0]  iKEY = 8'h00;

  logic [1:0]  bkg1, bkg8;
  logic [2:0]  addr1, addr8;
  logic [12:0] data1, data8;
  logic        we1, we8;

  int passed = 0;
  int total  = 0;

  logic [12:0] mem1 [8];
  logic [12:0] mem8 [8];
  int          wr1 = 0, wr8 = 0;
  bit          seqbad1 = 1'b0, seqbad8 = 1'b0;

  always #5 clk = ~clk;

  game_controller #(.MOVE_DIV(1)) dut1 (
    .clk         (clk),
    .reset_n     (reset_n),
    .iVS         (iVS),
    .iKEY        (iKEY),
    .change      (change),
    .oBkg_sel    (bkg1),
    .oObjRam_addr(addr1),
    .oObjRam_data(data1),
    .oObjRam_we  (we1)
  );

  game_controller #(.MOVE_DIV(8)) dut8 (
    .clk         (clk),
    .reset_n     (reset_n),
    .iVS         (iVS),
    .iKEY        (iKEY),
    .change      (change),
    .oBkg_sel    (bkg8),
    .oObjRam_addr(addr8),
    .oObjRam_data(data8),
    .oObjRam_we  (we8)
  );

  // Capture every write into a shadow RAM and note out-of-order addresses
  always @(negedge clk) begin
    if (we1) begin
      mem1[addr1] = data1;
      if (int'(addr1) != wr1) seqbad1 = 1'b1;
      wr1++;
    end
    if (we8) begin
      mem8[addr8] = data8;
      if (int'(addr8) != wr8) seqbad8 = 1'b1;
      wr8++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clr();
    wr1 = 0;
    wr8 = 0;
    seqbad1 = 1'b0;
    seqbad8 = 1'b0;
  endtask

  task automatic frame(input logic [7:0] k);
    clr();
    iKEY = k;
    repeat (3) @(posedge clk);
    iVS = 1'b1;
    repeat (16) @(posedge clk);
    iVS = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic pulse_change();
    change = 1'b1;
    repeat (8) @(posedge clk);
    change = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic check_burst(input string tag);
    check({tag, " writes"}, wr1, 8);
    check({tag, " addr order"}, {31'd0, seqbad1}, 0);
  endtask

  initial begin
    logic [12:0] exp_man [5];
    bit seen;
    exp_man = '{13'h841, 13'h840, 13'h840, 13'h840, 13'h840};

    // Reset
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst bkg", bkg1, 0);
    check("rst we", we1, 0);
    check("rst addr", addr1, 0);
    check("rst data", data1, 0);
    clr();
    #2 reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_burst("init");
    check("init slot0", mem1[0], 13'h0842);
    check("init slot1", mem1[1], 13'h14BB);
    for (int i = 2; i < 8; i++) check("init slot hidden", mem1[i], 0);
    check("init writes div8", wr8, 8);

    // Chaser up then down
    frame(8'h10);
    check_burst("chs up");
    check("chs up slot1", mem1[1], 13'h14BA);
    check("chs up slot0", mem1[0], 13'h0842);
    check("div8 no move", mem8[1], 13'h14BB);
    frame(8'h20);
    check("chs down slot1", mem1[1], 13'h14BB);
    check("chs down slot0", mem1[0], 13'h0842);

    // Man up with clamp at row 0
    for (int i = 0; i < 5; i++) begin
      frame(8'h01);
      check("man up clamp", mem1[0], exp_man[i]);
    end
    check("div8 before 8th", mem8[0], 13'h0842);

    // All man keys: up wins; divider moves on the 8th frame only
    frame(8'h0F);
    check("div8 8th frame", mem8[0], 13'h0841);
    check("prio clamp", mem1[0], 13'h0840);
    frame(8'h0F);
    check("div8 9th frame", mem8[0], 13'h0841);

    // Man right to column 39, then clamp
    for (int i = 0; i < 37; i++) frame(8'h08);
    check("man right 39", mem1[0], 13'h0CE0);
    frame(8'h08);
    frame(8'h08);
    check("man right clamp", mem1[0], 13'h0CE0);
    check("div8 right", mem8[0], 13'h08E1);

    // Chaser to (39,0): catch
    frame(8'h80);
    frame(8'h80);
    for (int i = 0; i < 27; i++) frame(8'h10);
    check_burst("catch");
    check("caught slot0", mem1[0], 13'h1CE0);
    check("caught slot1", mem1[1], 13'h14E0);
    frame(8'h44);
    check("frozen slot0", mem1[0], 13'h1CE0);
    check("frozen slot1", mem1[1], 13'h14E0);

    // Change: background steps, restart on next frame
    pulse_change();
    check("bkg after restart press", bkg1, 1);
    check("bkg div8", bkg8, 1);
    frame(8'h00);
    check("restart slot0", mem1[0], 13'h0842);
    check("restart slot1", mem1[1], 13'h14BB);

    // Background wrap with no catch pending
    pulse_change();
    check("bkg 2", bkg1, 2);
    pulse_change();
    check("bkg 3", bkg1, 3);
    pulse_change();
    check("bkg wrap 0", bkg1, 0);
    pulse_change();
    check("bkg 1", bkg1, 1);
    frame(8'h00);
    check("no-restart slot0", mem1[0], 13'h0842);
    check("no-restart slot1", mem1[1], 13'h14BB);

    // Reset in the middle of a sweep
    clr();
    iVS = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (we1) seen = 1'b1;
    end
    check("burst start seen", {31'd0, seen}, 1);
    repeat (3) @(posedge clk);
    #1;
    check("mid burst we", we1, 1);
    reset_n = 1'b0;
    #1;
    check("abort we", we1, 0);
    check("abort addr", addr1, 0);
    check("abort data", data1, 0);
    check("abort bkg", bkg1, 0);
    iVS = 1'b0;
    repeat (3) @(posedge clk);
    clr();
    #2 reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_burst("re-init");
    check("re-init slot0", mem1[0], 13'h0842);
    check("re-init slot1", mem1[1], 13'h14BB);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
